// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared encodings for the ALU-control stage. It holds the
//               ALUOp codes from the main control unit, the R-type funct
//               codes, the ALU operation codes and the MDU sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALUOp codes issued by the main control unit
    localparam logic [3:0] ALUOP_ADDI = 4'b0000;
    localparam logic [3:0] ALUOP_ORI  = 4'b0001;
    localparam logic [3:0] ALUOP_ANDI = 4'b0010;
    localparam logic [3:0] ALUOP_LUI  = 4'b0011;
    localparam logic [3:0] ALUOP_LW   = 4'b0100;
    localparam logic [3:0] ALUOP_SW   = 4'b0101;
    localparam logic [3:0] ALUOP_BEQ  = 4'b0110;
    localparam logic [3:0] R_TYPE     = 4'b0111;
    localparam logic [3:0] ALUOP_BNE  = 4'b1000;
    localparam logic [3:0] ALUOP_J    = 4'b1001;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;

    // ALU operation codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    // Loads/stores share the NOP encoding: the ALU idles while the memory
    // stage computes the address.
    localparam logic [3:0] OP_MEM  = 4'b1010;
    localparam logic [3:0] NOP_OP  = 4'b1010;
    localparam logic [3:0] OP_MULT = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;

    // MDU sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_control_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_pipe_if
// Description : Groups the ID-side request and EX-side result signals of the
//               ALU-control stage.
//               master : drives in_valid, alu_op, alu_function, stall_in and
//                        flush. It observes the stage outputs.
//               slave  : the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_control_pipe_if #(
    parameter int ALUOP_WIDTH = 4,
    parameter int FUNCT_WIDTH = 6,
    parameter int OPER_WIDTH  = 4
);
    logic                   in_valid;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic [FUNCT_WIDTH-1:0] alu_function;
    logic                   stall_in;
    logic                   flush;
    logic [OPER_WIDTH-1:0]  alu_operation;
    logic                   out_valid;
    logic                   jr_redirect;
    logic                   mdu_start;
    logic                   mdu_done;
    logic                   stall_out;

    modport master (
        output in_valid, alu_op, alu_function, stall_in, flush,
        input  alu_operation, out_valid, jr_redirect, mdu_start, mdu_done,
               stall_out
    );

    modport slave (
        input  in_valid, alu_op, alu_function, stall_in, flush,
        output alu_operation, out_valid, jr_redirect, mdu_start, mdu_done,
               stall_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational ALU-control decode. It is shared with the
//               single-cycle datapath.
//   i_alu_op       : ALUOp from the main control unit
//   i_alu_function : instruction funct field (used only for R-type)
//   i_in_valid     : qualifies o_is_jr / o_is_mdu
//   o_op           : ALU operation code (NOP_OP for unknown encodings)
//   o_is_jr        : valid JR instruction
//   o_is_mdu       : valid MULT or DIV instruction
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 4,
    parameter int FUNCT_WIDTH = 6,
    parameter int OPER_WIDTH  = 4
) (
    input  wire logic [ALUOP_WIDTH-1:0] i_alu_op,
    input  wire logic [FUNCT_WIDTH-1:0] i_alu_function,
    input  wire logic                   i_in_valid,
    output logic      [OPER_WIDTH-1:0]  o_op,
    output logic                        o_is_jr,
    output logic                        o_is_mdu
);

    logic w_jr;
    logic w_mdu;

    always_comb begin
        o_op  = OPER_WIDTH'(NOP_OP);
        w_jr  = 1'b0;
        w_mdu = 1'b0;
        case (i_alu_op)
            ALUOP_WIDTH'(R_TYPE): begin
                case (i_alu_function)
                    FUNCT_WIDTH'(FUNCT_ADD):  o_op = OPER_WIDTH'(OP_ADD);
                    FUNCT_WIDTH'(FUNCT_AND):  o_op = OPER_WIDTH'(OP_AND);
                    FUNCT_WIDTH'(FUNCT_OR):   o_op = OPER_WIDTH'(OP_OR);
                    FUNCT_WIDTH'(FUNCT_NOR):  o_op = OPER_WIDTH'(OP_NOR);
                    FUNCT_WIDTH'(FUNCT_SLL):  o_op = OPER_WIDTH'(OP_SLL);
                    FUNCT_WIDTH'(FUNCT_SRL):  o_op = OPER_WIDTH'(OP_SRL);
                    FUNCT_WIDTH'(FUNCT_SUB):  o_op = OPER_WIDTH'(OP_SUB);
                    FUNCT_WIDTH'(FUNCT_JR): begin
                        o_op = OPER_WIDTH'(OP_JMP);
                        w_jr = 1'b1;
                    end
                    FUNCT_WIDTH'(FUNCT_MULT): begin
                        o_op  = OPER_WIDTH'(OP_MULT);
                        w_mdu = 1'b1;
                    end
                    FUNCT_WIDTH'(FUNCT_DIV): begin
                        o_op  = OPER_WIDTH'(OP_DIV);
                        w_mdu = 1'b1;
                    end
                    default: o_op = OPER_WIDTH'(NOP_OP);
                endcase
            end
            ALUOP_WIDTH'(ALUOP_ADDI): o_op = OPER_WIDTH'(OP_ADD);
            ALUOP_WIDTH'(ALUOP_ANDI): o_op = OPER_WIDTH'(OP_AND);
            ALUOP_WIDTH'(ALUOP_ORI):  o_op = OPER_WIDTH'(OP_OR);
            ALUOP_WIDTH'(ALUOP_LUI):  o_op = OPER_WIDTH'(OP_LUI);
            ALUOP_WIDTH'(ALUOP_LW):   o_op = OPER_WIDTH'(OP_MEM);
            ALUOP_WIDTH'(ALUOP_SW):   o_op = OPER_WIDTH'(OP_MEM);
            ALUOP_WIDTH'(ALUOP_BEQ):  o_op = OPER_WIDTH'(OP_SUB);
            ALUOP_WIDTH'(ALUOP_BNE):  o_op = OPER_WIDTH'(OP_SUB);
            ALUOP_WIDTH'(ALUOP_J):    o_op = OPER_WIDTH'(OP_JMP);
            default:                  o_op = OPER_WIDTH'(NOP_OP);
        endcase
    end

    assign o_is_jr  = i_in_valid & w_jr;
    assign o_is_mdu = i_in_valid & w_mdu;

endmodule
`default_nettype wire

// File: rtl/alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_pipe
// Description : Registered ALU-control stage at the ID/EX boundary. It has
//               stall and flush support and a MULT/DIV busy sequencer that
//               back-pressures IF/ID until the MDU result is due.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : request (in_valid, alu_op, alu_function, stall_in, flush) and
//           result (alu_operation, out_valid, jr_redirect, mdu_start,
//           mdu_done, stall_out) signals
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 4,
    parameter int FUNCT_WIDTH = 6,
    parameter int OPER_WIDTH  = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_control_pipe_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    generate
        if (MULT_CYCLES < 2) begin : g_bad_mult_cycles
            $error("alu_control_pipe: MULT_CYCLES must be >= 2");
        end
        if (DIV_CYCLES < 2) begin : g_bad_div_cycles
            $error("alu_control_pipe: DIV_CYCLES must be >= 2");
        end
    endgenerate

    logic [OPER_WIDTH-1:0] w_op;
    logic                  w_is_jr;
    logic                  w_is_mdu;

    alu_ctrl_decode #(
        .ALUOP_WIDTH (ALUOP_WIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH),
        .OPER_WIDTH  (OPER_WIDTH)
    ) u_decode (
        .i_alu_op       (bus.alu_op),
        .i_alu_function (bus.alu_function),
        .i_in_valid     (bus.in_valid),
        .o_op           (w_op),
        .o_is_jr        (w_is_jr),
        .o_is_mdu       (w_is_mdu)
    );

    mdu_state_t            r_state;
    mdu_state_t            w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_next_count;
    logic [OPER_WIDTH-1:0] r_alu_operation;
    logic                  r_out_valid;
    logic                  r_jr_redirect;
    logic                  r_mdu_start;
    logic                  w_stall_out;
    logic                  w_mdu_done;
    logic                  w_load;

    assign w_mdu_done  = (r_state == ST_BUSY) && (r_count == '0);
    assign w_stall_out = (r_state == ST_BUSY) && (r_count != '0);
    assign w_load      = !(bus.stall_in || w_stall_out);

    // Sequencer next state. A new MDU op can only load when the stage is not
    // back-pressured, i.e. in IDLE or in the final (done) busy cycle. That
    // gives back-to-back MDU ops without a gap cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        if (bus.flush) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
        end else if (w_load && w_is_mdu) begin
            w_next_state = ST_BUSY;
            w_next_count = (w_op == OPER_WIDTH'(OP_DIV)) ? CNT_W'(DIV_CYCLES - 1)
                                                          : CNT_W'(MULT_CYCLES - 1);
        end else if (r_state == ST_BUSY) begin
            // The countdown ignores stall_in: the MDU runs regardless.
            if (r_count == '0) begin
                w_next_state = ST_IDLE;
            end else begin
                w_next_count = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_operation <= OPER_WIDTH'(NOP_OP);
            r_out_valid     <= 1'b0;
            r_jr_redirect   <= 1'b0;
            r_mdu_start     <= 1'b0;
        end else if (bus.flush) begin
            r_alu_operation <= OPER_WIDTH'(NOP_OP);
            r_out_valid     <= 1'b0;
            r_jr_redirect   <= 1'b0;
            r_mdu_start     <= 1'b0;
        end else if (!w_load) begin
            // The pulses drop while held, so a stalled JR/MDU op never
            // re-fires.
            r_jr_redirect <= 1'b0;
            r_mdu_start   <= 1'b0;
        end else begin
            r_alu_operation <= w_op;
            r_out_valid     <= bus.in_valid;
            r_jr_redirect   <= w_is_jr;
            r_mdu_start     <= w_is_mdu;
        end
    end

    assign bus.alu_operation = r_alu_operation;
    assign bus.out_valid     = r_out_valid;
    assign bus.jr_redirect   = r_jr_redirect;
    assign bus.mdu_start     = r_mdu_start;
    assign bus.mdu_done      = w_mdu_done;
    assign bus.stall_out     = w_stall_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_pipe
// Description : Self-checking bench for alu_control_pipe. It applies a table
//               of single-cycle decode vectors, then hand-written sequences
//               for stall, flush, MULT/DIV busy and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_pipe;
    import alu_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_control_pipe_if #(.ALUOP_WIDTH(4), .FUNCT_WIDTH(6), .OPER_WIDTH(4)) bus ();

    alu_control_pipe #(
        .ALUOP_WIDTH (4),
        .FUNCT_WIDTH (6),
        .OPER_WIDTH  (4),
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] alu_op;
        logic [5:0] funct;
        logic       in_valid;
        logic [3:0] exp_op;
        logic       exp_valid;
        logic       exp_jr;
        logic       exp_start;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic [3:0] a, input logic [5:0] f, input logic v,
                                input logic [3:0] eo, input logic ev, input logic ej,
                                input logic es);
        vec_t t;
        t.alu_op = a; t.funct = f; t.in_valid = v;
        t.exp_op = eo; t.exp_valid = ev; t.exp_jr = ej; t.exp_start = es;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [5:0] f);
        bus.in_valid     = v;
        bus.alu_op       = a;
        bus.alu_function = f;
    endtask

    // Packed view: {op[3:0], valid, jr, start, done, stall}
    function automatic logic [8:0] outs();
        return {bus.alu_operation, bus.out_valid, bus.jr_redirect,
                bus.mdu_start, bus.mdu_done, bus.stall_out};
    endfunction

    function automatic logic [8:0] ex(input logic [3:0] o, input logic v, input logic j,
                                      input logic s, input logic d, input logic st);
        return {o, v, j, s, d, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [5:0] rnd;

        rnd = 6'($urandom_range(0, 63));
        vecs[0]  = mk(R_TYPE,    FUNCT_ADD,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(ALUOP_LUI, rnd,        1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(4'b1111,   FUNCT_ADD,  1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(R_TYPE,    FUNCT_AND,  1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(R_TYPE,    FUNCT_OR,   1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(R_TYPE,    FUNCT_NOR,  1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(R_TYPE,    FUNCT_SLL,  1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(R_TYPE,    FUNCT_SRL,  1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(R_TYPE,    FUNCT_SUB,  1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(R_TYPE,    FUNCT_JR,   1'b1, 4'b1001, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(R_TYPE,    6'b111111,  1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(ALUOP_ADDI, 6'b011000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(ALUOP_ANDI, 6'b001000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(ALUOP_ORI,  6'b000000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        vecs[14] = mk(ALUOP_LW,   6'b100000, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(ALUOP_SW,   6'b100010, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(ALUOP_BEQ,  6'b000000, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(ALUOP_BNE,  6'b000000, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(ALUOP_J,    6'b001000, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0);
        vecs[19] = mk(R_TYPE,     FUNCT_JR,  1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);

        drive(1'b0, R_TYPE, FUNCT_ADD);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;

        // Reset held low
        #12;
        chk("reset_state", 32'(outs()), 32'(ex(4'b1010, 0, 0, 0, 0, 0)));
        @(negedge clk);
        reset = 1'b1;

        // Decode table, one vector per cycle
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].in_valid, vecs[i].alu_op, vecs[i].funct);
            tick();
            chk($sformatf("vec[%0d]", i), 32'(outs()),
                32'(ex(vecs[i].exp_op, vecs[i].exp_valid, vecs[i].exp_jr,
                       vecs[i].exp_start, 1'b0, 1'b0)));
        end

        // JR held by stall_in for three cycles: a single redirect pulse
        drive(1'b1, R_TYPE, FUNCT_JR);
        tick();
        chk("jr_pulse", 32'(outs()), 32'(ex(4'b1001, 1, 1, 0, 0, 0)));
        bus.stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("jr_stall[%0d]", k), 32'(outs()), 32'(ex(4'b1001, 1, 0, 0, 0, 0)));
        end
        bus.stall_in = 1'b0;
        drive(1'b0, R_TYPE, FUNCT_ADD);
        tick();
        chk("jr_release", 32'(outs()), 32'(ex(4'b0000, 0, 0, 0, 0, 0)));

        // MULT, then DIV presented while busy loads in the done cycle
        drive(1'b1, R_TYPE, FUNCT_MULT);
        tick();
        chk("mult_c1", 32'(outs()), 32'(ex(4'b1011, 1, 0, 1, 0, 1)));
        drive(1'b1, R_TYPE, FUNCT_DIV);
        tick();
        chk("mult_c2", 32'(outs()), 32'(ex(4'b1011, 1, 0, 0, 0, 1)));
        tick();
        chk("mult_c3", 32'(outs()), 32'(ex(4'b1011, 1, 0, 0, 0, 1)));
        tick();
        chk("mult_c4_done", 32'(outs()), 32'(ex(4'b1011, 1, 0, 0, 1, 0)));
        tick();
        chk("div_c1", 32'(outs()), 32'(ex(4'b1100, 1, 0, 1, 0, 1)));
        drive(1'b0, R_TYPE, FUNCT_ADD);
        tick();
        chk("div_c2", 32'(outs()), 32'(ex(4'b1100, 1, 0, 0, 0, 1)));
        bus.flush = 1'b1;
        tick();
        chk("div_flush", 32'(outs()), 32'(ex(4'b1010, 0, 0, 0, 0, 0)));
        bus.flush = 1'b0;

        // Full DIV occupancy: 31 stall cycles, then done
        drive(1'b1, R_TYPE, FUNCT_DIV);
        tick();
        drive(1'b0, R_TYPE, FUNCT_ADD);
        n = 0;
        for (int k = 0; k < 40 && bus.stall_out; k++) begin
            n++;
            tick();
        end
        chk("div_stall_cycles", 32'(n), 32'd31);
        chk("div_done", 32'(outs()), 32'(ex(4'b1100, 1, 0, 0, 1, 0)));
        tick();
        chk("div_idle", 32'(outs()), 32'(ex(4'b0000, 0, 0, 0, 0, 0)));

        // stall_in in the done cycle: stage holds, FSM still goes idle
        drive(1'b1, R_TYPE, FUNCT_MULT);
        tick();
        drive(1'b1, ALUOP_ORI, 6'b000000);
        tick();
        tick();
        bus.stall_in = 1'b1;
        tick();
        chk("done_stall_c4", 32'(outs()), 32'(ex(4'b1011, 1, 0, 0, 1, 0)));
        tick();
        chk("done_stall_hold", 32'(outs()), 32'(ex(4'b1011, 1, 0, 0, 0, 0)));
        bus.stall_in = 1'b0;
        tick();
        chk("done_stall_load", 32'(outs()), 32'(ex(4'b0010, 1, 0, 0, 0, 0)));

        // stall_in with toggling inputs: registers hold until release
        bus.stall_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k[0], k[0] ? ALUOP_ADDI : ALUOP_LUI, 6'b000000);
            tick();
            chk($sformatf("stall_hold[%0d]", k), 32'(outs()), 32'(ex(4'b0010, 1, 0, 0, 0, 0)));
        end
        bus.stall_in = 1'b0;
        drive(1'b1, ALUOP_LUI, 6'b000000);
        tick();
        chk("stall_release", 32'(outs()), 32'(ex(4'b0110, 1, 0, 0, 0, 0)));

        // flush together with a valid instruction drops it
        bus.flush = 1'b1;
        drive(1'b1, R_TYPE, FUNCT_ADD);
        tick();
        chk("flush_wins", 32'(outs()), 32'(ex(4'b1010, 0, 0, 0, 0, 0)));
        bus.flush = 1'b0;

        // Asynchronous reset mid-BUSY
        drive(1'b1, R_TYPE, FUNCT_MULT);
        tick();
        chk("mult_busy", 32'(outs()), 32'(ex(4'b1011, 1, 0, 1, 0, 1)));
        drive(1'b0, R_TYPE, FUNCT_ADD);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'(ex(4'b1010, 0, 0, 0, 0, 0)));
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("after_reset", 32'(outs()), 32'(ex(4'b0000, 0, 0, 0, 0, 0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
- Registered, parametrised ALU-control stage at the ID/EX boundary of the pipelined MIPS.
- Decodes {ALUOp, funct} into the ALU operation code and a JR flag, and registers the result with stall and flush support.
- Adds multi-cycle MULT/DIV sequencing. A busy counter back-pressures the pipeline until the multiply/divide unit (MDU) result is due.

Parameters:
ALUOP_WIDTH, 4, width of ALUOp from the main control unit
FUNCT_WIDTH, 6, width of the instruction funct field
OPER_WIDTH, 4, width of the ALU operation code
MULT_CYCLES, 4, total cycles a MULT occupies the MDU; must be >= 2
DIV_CYCLES, 32, total cycles a DIV occupies the MDU; must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  ID stage holds a valid instruction
alu_op  input  ALUOP_WIDTH  ALUOp from the control unit
alu_function  input  FUNCT_WIDTH  instruction funct field
stall_in  input  1  downstream hazard stall: hold the stage register
flush  input  1  squash the stage and abort any MDU sequence
alu_operation  output  OPER_WIDTH  registered ALU operation code
out_valid  output  1  registered valid bit
jr_redirect  output  1  registered one-cycle JR redirect pulse
mdu_start  output  1  one-cycle pulse when a MULT/DIV is accepted
mdu_done  output  1  high in the final busy cycle
stall_out  output  1  back-pressure to IF/ID: stage cannot accept

Behaviour:
- Decode is combinational. Its inputs are alu_op, alu_function and in_valid; its outputs are op, is_jr and is_mdu.
- R-type (alu_op = 0111) funct mapping:
  - 100000 ADD -> 0000
  - 100100 AND -> 0001
  - 100101 OR -> 0010
  - 100111 NOR -> 0011
  - 000000 SLL -> 0100
  - 000010 SRL -> 0101
  - 100010 SUB -> 0111
  - 001000 JR -> 1001, is_jr = 1
  - 011000 MULT -> 1011, is_mdu = 1
  - 011010 DIV -> 1100, is_mdu = 1
- I/J-type mapping; funct is ignored:
  - 0000 ADDI -> 0000
  - 0010 ANDI -> 0001
  - 0001 ORI -> 0010
  - 0011 LUI -> 0110
  - 0100 LW -> 1010
  - 0101 SW -> 1010
  - 0110 BEQ -> 0111
  - 1000 BNE -> 0111
  - 1001 J/JAL -> 1001
- Anything else decodes to 1010 (NOP_OP).
- Reset values (asynchronous, active-low):
  - alu_operation = 1010, out_valid = 0, jr_redirect = 0, mdu_start = 0.
  - FSM = IDLE, counter = 0.
- State machine states: IDLE and BUSY.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)).
- mdu_done = (state == BUSY) && (count == 0). It is combinational.
- stall_out = (state == BUSY) && (count != 0). It is combinational.
- Stage-register priority per clock edge: flush > hold > load.
  - Flush: out_valid <= 0, alu_operation <= 1010, jr_redirect <= 0, mdu_start <= 0, FSM <= IDLE, counter <= 0.
  - Hold (stall_in || stall_out): all registers keep their values; jr_redirect <= 0 and mdu_start <= 0. Pulses never repeat.
  - Load:
    - out_valid <= in_valid and alu_operation <= op.
    - jr_redirect <= in_valid & is_jr.
    - mdu_start <= in_valid & is_mdu.
- Counter and FSM updates:
  - Load of a valid MULT: state <= BUSY, count <= MULT_CYCLES-1.
  - Load of a valid DIV: state <= BUSY, count <= DIV_CYCLES-1.
  - In BUSY without flush, count decrements each cycle, independent of stall_in.
  - At count == 0 the FSM returns to IDLE unless a new MDU op loads on the same edge; in that case it re-enters BUSY with the new count.
- Latency:
  - Decode to outputs: 1 cycle.
  - MDU occupancy: exactly MULT_CYCLES or DIV_CYCLES cycles from the cycle mdu_start is high.
  - stall_out is high for the first N-1 of those cycles.
- Simultaneous events:
  - flush with in_valid: flush wins and the instruction is dropped.
  - stall_in in the mdu_done cycle: the stage holds, but the FSM still returns to IDLE.
- Out-of-range parameters: a MULT_CYCLES or DIV_CYCLES value below 2 is a generate-time $error.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - localparams for the ALUOp codes (R_TYPE = 0111 etc.);
  - funct codes;
  - operation codes (OP_ADD ... OP_DIV, NOP_OP = 1010);
  - an FSM state enum.
- One natural sub-module, alu_ctrl_decode: the purely combinational decode, reused by the single-cycle datapath.
- The sequencer/stage register stays in alu_control_pipe.

Test Plan:
- Reset held low, then released; apply R-type ADD (alu_op = 0111, funct = 100000, in_valid = 1) -> next cycle alu_operation = 0000, out_valid = 1, jr_redirect = 0.
- Apply LUI (alu_op = 0011, funct = random) -> alu_operation = 0110. Then apply an undefined alu_op 1111 -> alu_operation = 1010.
- Apply JR (0111/001000) for one cycle -> jr_redirect high for exactly 1 cycle, alu_operation = 1001. Repeat with stall_in held 3 cycles -> still a single pulse.
- Apply MULT with MULT_CYCLES = 4 -> mdu_start pulses once, stall_out high for 3 cycles, mdu_done high in cycle 4. A DIV presented in cycle 4 loads and busy restarts with count 31.
- Flush during cycle 2 of a DIV -> next cycle out_valid = 0, alu_operation = 1010, stall_out = 0, FSM IDLE. Drop reset low mid-BUSY -> all outputs at reset values asynchronously.
- Assert stall_in with in_valid toggling -> alu_operation and out_valid stay constant until stall_in drops, then load the current input.
